// File: rtl/stack_machine_p_if.sv
// Program/control/observe bundle for stack_machine_p; the bench drives the master side.
interface stack_machine_p_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int MEM_AW = 8
);
  localparam int INSTR_W = DATA_W + 4;

  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               start;
  logic               busy;
  logic               done;
  logic [1:0]         fault;
  logic [DATA_W-1:0]  top;
  logic [PC_W-1:0]    pc_o;
  logic [MEM_AW-1:0]  dbg_addr;
  logic [DATA_W-1:0]  dbg_data;

  modport master (
    output prog_we, prog_addr, prog_data, start, dbg_addr,
    input  busy, done, fault, top, pc_o, dbg_data
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, dbg_addr,
    output busy, done, fault, top, pc_o, dbg_data
  );
endinterface

// File: rtl/stack_machine_p.sv
// One-instruction-per-cycle stack processor with fault detection.
// Define STACK_MACHINE_DUPSWAP_EN to enable the DUP (11) and SWAP (12) opcodes.
module stack_machine_p #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int SP_W   = 4,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  stack_machine_p_if.slave  bus
);
  localparam int INSTR_W = DATA_W + 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_t;
  typedef enum logic [3:0] {
    OP_PUSHC = 4'd0,  OP_LOAD = 4'd1, OP_STORE = 4'd2, OP_ADD  = 4'd3,
    OP_SUB   = 4'd4,  OP_JMPF = 4'd5, OP_JMPB  = 4'd6, OP_BEQ  = 4'd7,
    OP_BNE   = 4'd8,  OP_BLE  = 4'd9, OP_BGT   = 4'd10, OP_DUP = 4'd11,
    OP_SWAP  = 4'd12, OP_HALT = 4'd15
  } opcode_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [SP_W:0]     sp;
  logic [1:0]        fault_q;
  logic              busy_q;
  logic              done_q;

  logic [INSTR_W-1:0] imem [2**PC_W];
  logic [DATA_W-1:0]  stk  [2**SP_W];
  logic [DATA_W-1:0]  dmem [2**MEM_AW];

  logic [INSTR_W-1:0] instr;
  opcode_t            op;
  logic [DATA_W-1:0]  k, a, b;
  logic [PC_W-1:0]    k_pc, pc_inc;
  logic [MEM_AW-1:0]  k_addr;
  logic [SP_W-1:0]    ip, ia, ib;
  logic               push, illegal;
  logic [SP_W:0]      need;
  logic [1:0]         fcode;
  logic               exec;

  logic               wa_en, wb_en, mem_we;
  logic [SP_W-1:0]    wa_idx, wb_idx;
  logic [DATA_W-1:0]  wa_dat, wb_dat;
  logic [PC_W-1:0]    pc_nx;
  logic [SP_W:0]      sp_nx;

  assign instr  = imem[pc];
  assign op     = opcode_t'(instr[INSTR_W-1 -: 4]);
  assign k      = instr[DATA_W-1:0];
  assign k_pc   = PC_W'(k);
  assign k_addr = MEM_AW'(k);
  assign pc_inc = pc + PC_W'(1);
  assign ip     = sp[SP_W-1:0];
  assign ia     = sp[SP_W-1:0] - SP_W'(1);
  assign ib     = sp[SP_W-1:0] - SP_W'(2);
  assign a      = stk[ia];
  assign b      = stk[ib];

  // Fault classification happens before any state is touched; priority illegal > underflow > overflow.
  always_comb begin
    push    = 1'b0;
    need    = '0;
    illegal = 1'b0;
    case (op)
      OP_PUSHC, OP_LOAD:                   push = 1'b1;
      OP_STORE:                            need = (SP_W+1)'(1);
      OP_ADD, OP_SUB, OP_BEQ, OP_BNE,
      OP_BLE, OP_BGT:                      need = (SP_W+1)'(2);
      OP_JMPF, OP_JMPB, OP_HALT:           ;
`ifdef STACK_MACHINE_DUPSWAP_EN
      OP_DUP:  begin push = 1'b1; need = (SP_W+1)'(1); end
      OP_SWAP:                             need = (SP_W+1)'(2);
`endif
      default:                             illegal = 1'b1;
    endcase
    if (illegal)                                 fcode = 2'b11;
    else if (sp < need)                          fcode = 2'b10;
    else if (push && sp == {1'b1, {SP_W{1'b0}}}) fcode = 2'b01;
    else                                         fcode = 2'b00;
  end

  assign exec = (state == S_RUN) && (fcode == 2'b00);

  always_comb begin
    wa_en  = 1'b0;  wa_idx = ip;  wa_dat = k;
    wb_en  = 1'b0;  wb_idx = ib;  wb_dat = a;
    mem_we = 1'b0;
    pc_nx  = pc_inc;
    sp_nx  = sp;
    case (op)
      OP_PUSHC: begin wa_en = 1'b1; sp_nx = sp + (SP_W+1)'(1); end
      OP_LOAD:  begin wa_en = 1'b1; wa_dat = dmem[k_addr]; sp_nx = sp + (SP_W+1)'(1); end
      OP_STORE: begin mem_we = 1'b1; sp_nx = sp - (SP_W+1)'(1); end
      OP_ADD:   begin wa_en = 1'b1; wa_idx = ib; wa_dat = b + a; sp_nx = sp - (SP_W+1)'(1); end
      OP_SUB:   begin wa_en = 1'b1; wa_idx = ib; wa_dat = b - a; sp_nx = sp - (SP_W+1)'(1); end
      OP_JMPF:  pc_nx = pc_inc + k_pc;
      OP_JMPB:  pc_nx = pc_inc - k_pc;
      OP_BEQ:   begin sp_nx = sp - (SP_W+1)'(2); if (b == a) pc_nx = pc_inc + k_pc; end
      OP_BNE:   begin sp_nx = sp - (SP_W+1)'(2); if (b != a) pc_nx = pc_inc + k_pc; end
      OP_BLE:   begin sp_nx = sp - (SP_W+1)'(2); if (b <= a) pc_nx = pc_inc + k_pc; end
      OP_BGT:   begin sp_nx = sp - (SP_W+1)'(2); if (b >  a) pc_nx = pc_inc + k_pc; end
`ifdef STACK_MACHINE_DUPSWAP_EN
      OP_DUP:   begin wa_en = 1'b1; wa_dat = a; sp_nx = sp + (SP_W+1)'(1); end
      OP_SWAP:  begin wa_en = 1'b1; wa_idx = ia; wa_dat = b; wb_en = 1'b1; end
`endif
      OP_HALT:  pc_nx = pc;
      default:  ;
    endcase
  end

  // Storage arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy_q) imem[bus.prog_addr] <= bus.prog_data;
    if (exec && wa_en)          stk[wa_idx]         <= wa_dat;
    if (exec && wb_en)          stk[wb_idx]         <= wb_dat;
    if (exec && mem_we)         dmem[k_addr]        <= a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      sp      <= '0;
      fault_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (fcode != 2'b00) begin
            state   <= S_FAULT;
            fault_q <= fcode;
            busy_q  <= 1'b0;
          end else begin
            pc <= pc_nx;
            sp <= sp_nx;
            if (op == OP_HALT) begin
              state  <= S_HALT;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.start) begin
            state   <= S_RUN;
            pc      <= '0;
            sp      <= '0;
            fault_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.fault    = fault_q;
  assign bus.pc_o     = pc;
  assign bus.top      = (sp == '0) ? '0 : a;
  assign bus.dbg_data = dmem[bus.dbg_addr];
endmodule

// File: tb/tb_stack_machine_p.sv
// Directed-vector bench for stack_machine_p (DATA_W=8, PC_W=8, SP_W=4, MEM_AW=8).
module tb_stack_machine_p;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc;

  always #5 clk = ~clk;

  stack_machine_p_if #(.DATA_W(8), .PC_W(8), .MEM_AW(8)) bus ();

  stack_machine_p #(.DATA_W(8), .PC_W(8), .SP_W(4), .MEM_AW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] k);
    return {op, k};
  endfunction

  task automatic load(input int addr, input logic [11:0] w);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr[7:0];
    bus.prog_data = w;
    @(negedge clk);
    bus.prog_we   = 1'b0;
  endtask

  task automatic kick(input logic we0, input logic [11:0] w0);
    @(negedge clk);
    bus.start = 1'b1;
    if (we0) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 8'd0;
      bus.prog_data = w0;
    end
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    check_eq("busy_after_start", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic wait_end(input int max, output int n);
    n = 0;
    while (!bus.done && bus.fault == 2'b00 && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("run_finished", {31'd0, bus.done | (bus.fault != 2'b00)}, 32'd1);
  endtask

  task automatic peek(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    bus.dbg_addr = addr;
    #1;
    check_eq(tag, {24'd0, bus.dbg_data}, {24'd0, exp});
  endtask

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;
    bus.dbg_addr  = '0;
    #12 rst_n = 1'b1;
    #1;
    check_eq("rst_busy",  {31'd0, bus.busy},  32'd0);
    check_eq("rst_done",  {31'd0, bus.done},  32'd0);
    check_eq("rst_fault", {30'd0, bus.fault}, 32'd0);
    check_eq("rst_pc",    {24'd0, bus.pc_o},  32'd0);
    check_eq("rst_top",   {24'd0, bus.top},   32'd0);

    // P1: 5+3 stored to mem[7]
    load(0, ins(4'd0, 8'd5)); load(1, ins(4'd0, 8'd3)); load(2, ins(4'd3, 8'd0));
    load(3, ins(4'd2, 8'd7)); load(4, ins(4'd15, 8'd0));
    kick(1'b0, '0); wait_end(50, cyc);
    check_eq("p1_cycles", cyc, 32'd5);
    check_eq("p1_done",   {31'd0, bus.done}, 32'd1);
    check_eq("p1_busy",   {31'd0, bus.busy}, 32'd0);
    check_eq("p1_top",    {24'd0, bus.top},  32'd0);
    check_eq("p1_pc",     {24'd0, bus.pc_o}, 32'd4);
    peek("p1_mem7", 8'd7, 8'd8);

    // P2: 2-3 wraps; address 0 written in the same cycle as start
    load(0, ins(4'd15, 8'd0)); load(1, ins(4'd0, 8'd3)); load(2, ins(4'd4, 8'd0));
    load(3, ins(4'd15, 8'd0));
    kick(1'b1, ins(4'd0, 8'd2)); wait_end(50, cyc);
    check_eq("p2_cycles", cyc, 32'd4);
    check_eq("p2_top",    {24'd0, bus.top},  32'd255);
    check_eq("p2_done",   {31'd0, bus.done}, 32'd1);

    // P3: countdown from 4 with BNE/JMPB loop, exit via JMPF 234 to 255 then wrapping JMPF 4
    load(0, ins(4'd0, 8'd4));   load(1, ins(4'd2, 8'd9));   load(2, ins(4'd5, 8'd10));
    load(3, ins(4'd15, 8'd0));  load(4, ins(4'd15, 8'd0));
    load(13, ins(4'd1, 8'd9));  load(14, ins(4'd0, 8'd1));  load(15, ins(4'd4, 8'd0));
    load(16, ins(4'd2, 8'd9));  load(17, ins(4'd1, 8'd9));  load(18, ins(4'd0, 8'd0));
    load(19, ins(4'd8, 8'd1));  load(20, ins(4'd5, 8'd234)); load(21, ins(4'd6, 8'd9));
    load(255, ins(4'd5, 8'd4));
    kick(1'b0, '0); wait_end(100, cyc);
    check_eq("p3_cycles", cyc, 32'd37);
    check_eq("p3_pc",     {24'd0, bus.pc_o}, 32'd4);
    check_eq("p3_done",   {31'd0, bus.done}, 32'd1);
    peek("p3_mem9", 8'd9, 8'd0);

    // Asynchronous reset in the middle of the loop, then a clean rerun
    kick(1'b0, '0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("mid_pc",   {24'd0, bus.pc_o}, 32'd21);
    check_eq("mid_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy",  {31'd0, bus.busy},  32'd0);
    check_eq("arst_done",  {31'd0, bus.done},  32'd0);
    check_eq("arst_fault", {30'd0, bus.fault}, 32'd0);
    check_eq("arst_pc",    {24'd0, bus.pc_o},  32'd0);
    @(negedge clk); rst_n = 1'b1;
    kick(1'b0, '0); wait_end(100, cyc);
    check_eq("rerun_cycles", cyc, 32'd37);
    peek("rerun_mem9", 8'd9, 8'd0);

    // P4: 17 pushes overflow a 16-deep stack
    for (int i = 0; i < 17; i++) load(i, ins(4'd0, 8'(i + 1)));
    load(17, ins(4'd15, 8'd0));
    kick(1'b0, '0); wait_end(50, cyc);
    check_eq("p4_cycles", cyc, 32'd17);
    check_eq("p4_fault",  {30'd0, bus.fault}, 32'd1);
    check_eq("p4_pc",     {24'd0, bus.pc_o},  32'd16);
    check_eq("p4_busy",   {31'd0, bus.busy},  32'd0);
    check_eq("p4_top",    {24'd0, bus.top},   32'd16);

    // P5: ADD on an empty stack
    load(0, ins(4'd3, 8'd0));
    kick(1'b0, '0); wait_end(20, cyc);
    check_eq("p5_fault", {30'd0, bus.fault}, 32'd2);
    check_eq("p5_pc",    {24'd0, bus.pc_o},  32'd0);
    check_eq("p5_top",   {24'd0, bus.top},   32'd0);

    // P6: opcode 11 (DUP when enabled, illegal otherwise)
    load(0, ins(4'd0, 8'd9)); load(1, ins(4'd11, 8'd0)); load(2, ins(4'd15, 8'd0));
    kick(1'b0, '0); wait_end(20, cyc);
`ifdef STACK_MACHINE_DUPSWAP_EN
    check_eq("p6_cycles", cyc, 32'd3);
    check_eq("p6_done",   {31'd0, bus.done},  32'd1);
    check_eq("p6_top",    {24'd0, bus.top},   32'd9);
`else
    check_eq("p6_cycles", cyc, 32'd2);
    check_eq("p6_fault",  {30'd0, bus.fault}, 32'd3);
    check_eq("p6_pc",     {24'd0, bus.pc_o},  32'd1);
    check_eq("p6_top",    {24'd0, bus.top},   32'd9);
`endif

    // P7: STORE then LOAD same address, taken BGT; a prog_we while busy is dropped
    load(0, ins(4'd0, 8'h5A)); load(1, ins(4'd2, 8'd20)); load(2, ins(4'd1, 8'd20));
    load(3, ins(4'd0, 8'h30)); load(4, ins(4'd10, 8'd1)); load(5, ins(4'd15, 8'd0));
    load(6, ins(4'd0, 8'h11)); load(7, ins(4'd15, 8'd0));
    kick(1'b0, '0);
    @(negedge clk);
    bus.prog_we = 1'b1; bus.prog_addr = 8'd6; bus.prog_data = ins(4'd0, 8'hEE);
    @(negedge clk);
    bus.prog_we = 1'b0;
    wait_end(50, cyc);
    check_eq("p7_top",  {24'd0, bus.top},  32'h11);
    check_eq("p7_pc",   {24'd0, bus.pc_o}, 32'd7);
    check_eq("p7_done", {31'd0, bus.done}, 32'd1);
    peek("p7_mem20", 8'd20, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
